exmem_stage: RTL and testbench

//  EX/MEM pipeline stage. Sits directly downstream of the ID/EX register and ALU.

---
 rtl/exmem_stage.sv | 178 +++++++++++++++++
 tb/tb_exmem_stage.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/exmem_stage.sv
// EX/MEM pipeline stage: registers the ALU result, store data and control
// for one instruction, issues a single-pulse data-memory request for loads
// and stores, stalls upstream until the access completes, latches load data
// and freezes permanently once a dump (halt) instruction is resident.
module exmem_stage #(
    parameter int             DW        = 16,
    parameter int             RW        = 3,
    parameter logic [DW-1:0]  NOP_INSTR = 16'h0800
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [DW-1:0] instr_in,
    input  logic [DW-1:0] alu_in,
    input  logic [DW-1:0] B_in,
    input  logic [DW-1:0] nextPC_in,
    input  logic [RW-1:0] wreg_in,
    input  logic          mem_write_in,
    input  logic          mem_to_reg_in,
    input  logic          reg_write_in,
    input  logic          dump_in,
    input  logic          mem_done,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] instr_out,
    output logic [DW-1:0] alu_out,
    output logic [DW-1:0] B_out,
    output logic [DW-1:0] nextPC_out,
    output logic [RW-1:0] wreg_out,
    output logic          mem_write_out,
    output logic          mem_to_reg_out,
    output logic          reg_write_out,
    output logic          dump_out,
    output logic          mem_en,
    output logic          mem_wr,
    output logic [DW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic [DW-1:0] rdata_out,
    output logic          stall_out,
    output logic          halted
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_HALT   = 2'b10
    } state_t;

    state_t state_r;
    state_t next_state_s;
    logic   served_r;
    logic   load_s;
    logic   memop_s;
    logic   rd_upd_s;

    // A store flag wins over a load flag, so the request direction is simply the store bit.
    assign memop_s   = mem_write_out | mem_to_reg_out;
    assign load_s    = en & ~stall_out;
    assign mem_wr    = mem_write_out;
    assign mem_addr  = alu_out;
    assign mem_wdata = B_out;
    assign halted    = (state_r == ST_HALT);

    // Pipeline register: capture the upstream instruction when the stage is free to advance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_out      <= NOP_INSTR;
            alu_out        <= {DW{1'b0}};
            B_out          <= {DW{1'b0}};
            nextPC_out     <= {DW{1'b0}};
            wreg_out       <= {RW{1'b0}};
            mem_write_out  <= 1'b0;
            mem_to_reg_out <= 1'b0;
            reg_write_out  <= 1'b0;
            dump_out       <= 1'b0;
        end else if (load_s) begin
            instr_out      <= instr_in;
            alu_out        <= alu_in;
            B_out          <= B_in;
            nextPC_out     <= nextPC_in;
            wreg_out       <= wreg_in;
            mem_write_out  <= mem_write_in;
            mem_to_reg_out <= mem_to_reg_in;
            reg_write_out  <= reg_write_in;
            dump_out       <= dump_in;
        end else begin
            instr_out      <= instr_out;
            alu_out        <= alu_out;
            B_out          <= B_out;
            nextPC_out     <= nextPC_out;
            wreg_out       <= wreg_out;
            mem_write_out  <= mem_write_out;
            mem_to_reg_out <= mem_to_reg_out;
            reg_write_out  <= reg_write_out;
            dump_out       <= dump_out;
        end
    end

    // Served flag: remembers that the resident entry already issued its request,
    // so holding the stage (en=0) never produces a second pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            served_r <= 1'b0;
        end else if (load_s) begin
            served_r <= 1'b0;
        end else if (mem_en) begin
            served_r <= 1'b1;
        end else begin
            served_r <= served_r;
        end
    end

    // State register for the memory-handshake / halt controller.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state and handshake outputs; a resident dump keeps the stage frozen
    // so nothing behind it is accepted while the halt takes effect.
    always_comb begin
        next_state_s = state_r;
        mem_en       = 1'b0;
        stall_out    = 1'b0;
        rd_upd_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (memop_s && !served_r) begin
                    mem_en = 1'b1;
                    if (mem_done) begin
                        rd_upd_s     = ~mem_write_out;
                        stall_out    = dump_out;
                        next_state_s = dump_out ? ST_HALT : ST_IDLE;
                    end else begin
                        stall_out    = 1'b1;
                        next_state_s = ST_ACCESS;
                    end
                end else if (dump_out) begin
                    stall_out    = 1'b1;
                    next_state_s = ST_HALT;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (mem_done) begin
                    rd_upd_s     = ~mem_write_out;
                    stall_out    = dump_out;
                    next_state_s = dump_out ? ST_HALT : ST_IDLE;
                end else begin
                    stall_out    = 1'b1;
                    next_state_s = ST_ACCESS;
                end
            end
            ST_HALT: begin
                stall_out    = 1'b1;
                next_state_s = ST_HALT;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Load-data latch: only a completion belonging to an outstanding load updates it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_out <= {DW{1'b0}};
        end else if (rd_upd_s) begin
            rdata_out <= mem_rdata;
        end else begin
            rdata_out <= rdata_out;
        end
    end

endmodule

// File: tb/tb_exmem_stage.sv
// Directed bench for exmem_stage: reset, ALU pass-through, waited load,
// zero-wait store, hold during access, stray completion, reset mid-access, halt.
module tb_exmem_stage;

    logic        clk;
    logic        rst;
    logic        en;
    logic [15:0] instr_in, alu_in, B_in, nextPC_in;
    logic [2:0]  wreg_in;
    logic        mem_write_in, mem_to_reg_in, reg_write_in, dump_in;
    logic        mem_done;
    logic [15:0] mem_rdata;
    logic [15:0] instr_out, alu_out, B_out, nextPC_out;
    logic [2:0]  wreg_out;
    logic        mem_write_out, mem_to_reg_out, reg_write_out, dump_out;
    logic        mem_en, mem_wr;
    logic [15:0] mem_addr, mem_wdata, rdata_out;
    logic        stall_out, halted;

    int n_asserts = 0;
    int n_fails   = 0;
    int pulse_cnt = 0;

    exmem_stage dut (
        .clk(clk), .rst(rst), .en(en),
        .instr_in(instr_in), .alu_in(alu_in), .B_in(B_in), .nextPC_in(nextPC_in),
        .wreg_in(wreg_in), .mem_write_in(mem_write_in), .mem_to_reg_in(mem_to_reg_in),
        .reg_write_in(reg_write_in), .dump_in(dump_in),
        .mem_done(mem_done), .mem_rdata(mem_rdata),
        .instr_out(instr_out), .alu_out(alu_out), .B_out(B_out), .nextPC_out(nextPC_out),
        .wreg_out(wreg_out), .mem_write_out(mem_write_out), .mem_to_reg_out(mem_to_reg_out),
        .reg_write_out(reg_write_out), .dump_out(dump_out),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .rdata_out(rdata_out), .stall_out(stall_out), .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count request cycles seen at each rising edge.
    always @(posedge clk) begin
        if (mem_en === 1'b1) pulse_cnt = pulse_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] ins, input logic [15:0] alu, input logic [15:0] b,
                         input logic mw, input logic mr, input logic rw, input logic dmp);
        instr_in = ins; alu_in = alu; B_in = b; nextPC_in = ins + 16'd2; wreg_in = ins[2:0];
        mem_write_in = mw; mem_to_reg_in = mr; reg_write_in = rw; dump_in = dmp;
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; mem_done = 1'b0; mem_rdata = 16'h0000;
        drive(16'h0800, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        #12;
        // 1. reset state
        check("rst_instr",  instr_out, 16'h0800);
        check("rst_stall",  stall_out, 1'b0);
        check("rst_memen",  mem_en,    1'b0);
        check("rst_halted", halted,    1'b0);
        check("rst_rdata",  rdata_out, 16'h0000);
        rst = 1'b1;

        // 2. ALU op passes through in one cycle, no request
        en = 1'b1;
        drive(16'h1111, 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        check("alu_out",    alu_out, 16'h1234);
        check("alu_rw",     reg_write_out, 1'b1);
        check("alu_instr",  instr_out, 16'h1111);
        check("alu_nextpc", nextPC_out, 16'h1113);
        check("alu_memen",  mem_en, 1'b0);
        check("alu_stall",  stall_out, 1'b0);

        // 3. load with three stall cycles
        drive(16'h2222, 16'h0040, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        drive(16'h3333, 16'h0007, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
        check("ld_memen",   mem_en, 1'b1);
        check("ld_memwr",   mem_wr, 1'b0);
        check("ld_addr",    mem_addr, 16'h0040);
        check("ld_stall0",  stall_out, 1'b1);
        tick();
        check("ld_memen1",  mem_en, 1'b0);
        check("ld_stall1",  stall_out, 1'b1);
        check("ld_hold",    instr_out, 16'h2222);
        tick();
        check("ld_stall2",  stall_out, 1'b1);
        tick();
        mem_done = 1'b1; mem_rdata = 16'hBEEF; #1;
        check("ld_stall3",  stall_out, 1'b0);
        check("ld_memen3",  mem_en, 1'b0);
        tick();
        mem_done = 1'b0; mem_rdata = 16'h0000; #1;
        check("ld_rdata",   rdata_out, 16'hBEEF);
        check("ld_next",    instr_out, 16'h3333);
        check("ld_after",   stall_out, 1'b0);

        // 4. zero-wait store, then a bubble
        drive(16'h4444, 16'h0050, 16'hA5A5, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        drive(16'h0800, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        mem_done = 1'b1; mem_rdata = 16'h1111; #1;
        check("st_memen",   mem_en, 1'b1);
        check("st_memwr",   mem_wr, 1'b1);
        check("st_wdata",   mem_wdata, 16'hA5A5);
        check("st_addr",    mem_addr, 16'h0050);
        check("st_stall",   stall_out, 1'b0);
        tick();
        mem_done = 1'b0; #1;
        check("st_rdhold",  rdata_out, 16'hBEEF);
        check("bub_instr",  instr_out, 16'h0800);
        check("bub_memen",  mem_en, 1'b0);
        check("bub_stall",  stall_out, 1'b0);

        // 5. en dropped during an access wait
        drive(16'h6666, 16'h0060, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        check("en0_req",    mem_en, 1'b1);
        en = 1'b0;
        drive(16'h7777, 16'h0008, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        check("en0_wait",   stall_out, 1'b1);
        tick();
        mem_done = 1'b1; mem_rdata = 16'hCAFE; #1;
        check("en0_done",   stall_out, 1'b0);
        tick();
        mem_done = 1'b0; #1;
        check("en0_hold",   instr_out, 16'h6666);
        check("en0_noreq",  mem_en, 1'b0);
        check("en0_rdata",  rdata_out, 16'hCAFE);
        tick();
        check("en0_noreq2", mem_en, 1'b0);
        check("en0_pulses", pulse_cnt, 32'd3);
        en = 1'b1;
        tick();
        check("en1_load",   instr_out, 16'h7777);

        // stray completion with nothing outstanding
        mem_done = 1'b1; mem_rdata = 16'hDEAD;
        tick();
        mem_done = 1'b0; #1;
        check("stray_rd",   rdata_out, 16'hCAFE);

        // reset asserted mid-access
        drive(16'h8888, 16'h0070, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        drive(16'h0800, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check("mr_stall",   stall_out, 1'b1);
        rst = 1'b0; #1;
        check("mr_rst_stl", stall_out, 1'b0);
        check("mr_rst_ins", instr_out, 16'h0800);
        #2 rst = 1'b1;
        mem_done = 1'b1; mem_rdata = 16'h1234;
        tick();
        mem_done = 1'b0; #1;
        check("mr_rdata",   rdata_out, 16'h0000);
        check("mr_memen",   mem_en, 1'b0);

        // 6. halt
        drive(16'h9999, 16'h0009, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        check("dmp_out",    dump_out, 1'b1);
        check("dmp_nohalt", halted, 1'b0);
        drive(16'hAAAA, 16'h0044, 16'h5555, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        check("hlt_halted", halted, 1'b1);
        check("hlt_stall",  stall_out, 1'b1);
        tick(); tick(); tick();
        check("hlt_instr",  instr_out, 16'h9999);
        check("hlt_memen",  mem_en, 1'b0);
        check("hlt_stick",  halted, 1'b1);
        check("hlt_pulses", pulse_cnt, 32'd4);
        rst = 1'b0; #1;
        check("hlt_clear",  halted, 1'b0);
        check("hlt_rinstr", instr_out, 16'h0800);
        rst = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
